fir_out_packer: RTL and testbench

Downstream output stage of the FIR filter. Captures each completed filter result `y_n` on a one-cycle strobe and buffers it in a small sample FIFO. Each sample is serialized as two sign-extended bytes, high byte first, over an 8-bit valid/ready byte stream to the chip output pins. Samples are dropped while the FIFO is full, and a sticky overflow flag records the loss.

---
 rtl/fir_out_packer.sv | 99 +++++++++
 tb/tb_fir_out_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_packer.sv
// Output stage of the FIR filter: buffers signed results in a small FIFO and
// streams each one as two sign-extended bytes (high first) over valid/ready.
module fir_out_packer #(
    parameter int Y_N_SIZE   = 11,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Y_N_SIZE-1:0] i_y_n,
    input  logic                i_valid,
    input  logic                i_clr_ovf,
    output logic [7:0]          o_byte,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [LW-1:0]       o_level,
    output logic                o_overflow
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t              state_q, state_d;
    logic [Y_N_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [15:0]         hold_q, hold_d;
    logic [7:0]          byte_q, byte_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic xfer, pop, full, wr, drop;

    always_comb begin
        xfer = (state_q != IDLE) && i_ready;
        // A pop happens whenever the hold register is (or is about to become) free.
        pop  = (level_q != '0) && ((state_q == IDLE) || ((state_q == LO) && xfer));
        full = (level_q == LW'(FIFO_DEPTH));
        wr   = i_valid && (!full || pop);
        drop = i_valid && !wr;

        state_d  = state_q;
        hold_d   = hold_q;
        wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + LW'(wr) - LW'(pop);
        ovf_d    = drop | (ovf_q & ~i_clr_ovf);

        if (pop) hold_d = 16'(signed'(mem_q[rd_ptr_q]));

        case (state_q)
            IDLE:    if (pop) state_d = HI;
            HI:      if (xfer) state_d = LO;
            LO:      if (xfer) state_d = pop ? HI : IDLE;
            default: state_d = IDLE;
        endcase

        valid_d = (state_d != IDLE);
        case (state_d)
            HI:      byte_d = hold_d[15:8];
            LO:      byte_d = hold_d[7:0];
            default: byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: pointers and level define what is live.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= i_y_n;
    end

    assign o_byte     = byte_q;
    assign o_valid    = valid_q;
    assign o_level    = level_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_fir_out_packer.sv
// Bench for fir_out_packer: queue-based reference model compared every cycle,
// plus directed literal checks for format, streaming, overflow and reset.
module tb_fir_out_packer;
    localparam int YW = 11;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [YW-1:0] i_y_n = '0;
    logic          i_valid = 1'b0;
    logic          i_clr_ovf = 1'b0;
    logic          i_ready = 1'b0;
    logic [7:0]    o_byte;
    logic          o_valid;
    logic [LW-1:0] o_level;
    logic          o_overflow;

    int n_tot = 0;
    int n_pass = 0;

    fir_out_packer #(.Y_N_SIZE(YW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .i_y_n(i_y_n), .i_valid(i_valid),
        .i_clr_ovf(i_clr_ovf), .o_byte(o_byte), .o_valid(o_valid),
        .i_ready(i_ready), .o_level(o_level), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Reference model: sample queue plus the bytes still owed for the current sample.
    logic [YW-1:0] mq[$];
    int            pend[$];
    bit            movf = 1'b0;
    int            m_lvl, m_sx;
    bit            m_pop, m_drop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            pend.delete();
            movf = 1'b0;
        end else begin
            m_lvl = mq.size();
            if (pend.size() > 0 && i_ready) void'(pend.pop_front());
            m_pop = (pend.size() == 0) && (m_lvl > 0);
            if (m_pop) begin
                m_sx = int'(mq.pop_front());
                if (m_sx >= (1 << (YW - 1))) m_sx = m_sx - (1 << YW);
                pend.push_back((m_sx >> 8) & 255);
                pend.push_back(m_sx & 255);
            end
            m_drop = 1'b0;
            if (i_valid) begin
                if (m_lvl < DEPTH || m_pop) mq.push_back(i_y_n);
                else m_drop = 1'b1;
            end
            if (i_clr_ovf) movf = 1'b0;
            if (m_drop) movf = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("m_valid", int'(o_valid), (pend.size() > 0) ? 1 : 0);
        chk("m_byte", int'(o_byte), (pend.size() > 0) ? pend[0] : 0);
        chk("m_level", int'(o_level), mq.size());
        chk("m_ovf", int'(o_overflow), int'(movf));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic collect(input int cycles, output int got[$]);
        got.delete();
        for (int c = 0; c < cycles; c++) begin
            if (o_valid && i_ready) got.push_back(int'(o_byte));
            tick();
        end
    endtask

    logic [YW-1:0] fv[3] = '{11'h155, 11'h7FF, 11'h400};
    int            fh[3] = '{8'h01, 8'hFF, 8'hFC};
    int            fl[3] = '{8'h55, 8'hFF, 8'h00};
    int            sexp[6] = '{0, 1, 0, 2, 0, 3};
    int            got[$];

    initial begin
        // Reset with random inputs
        for (int c = 0; c < 4; c++) begin
            i_y_n = YW'($urandom); i_valid = 1'($urandom); i_ready = 1'($urandom);
            i_clr_ovf = 1'($urandom);
            tick();
        end
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_byte", int'(o_byte), 0);
        chk("rst_level", int'(o_level), 0);
        chk("rst_ovf", int'(o_overflow), 0);
        i_valid = 0; i_clr_ovf = 0; i_ready = 1;
        reset = 1;
        tick(); tick();

        // Byte format and 2-cycle latency
        for (int i = 0; i < 3; i++) begin
            i_y_n = fv[i]; i_valid = 1;
            tick();
            i_valid = 0;
            chk("fmt_lat_valid0", int'(o_valid), 0);
            chk("fmt_level1", int'(o_level), 1);
            tick();
            chk("fmt_hi_valid", int'(o_valid), 1);
            chk("fmt_hi", int'(o_byte), fh[i]);
            tick();
            chk("fmt_lo", int'(o_byte), fl[i]);
            tick();
            chk("fmt_idle", int'(o_valid), 0);
        end

        // Back-to-back samples, no bubble
        i_y_n = 1; i_valid = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) i_y_n = 2;
            if (i == 1) i_y_n = 3;
            if (i == 2) i_valid = 0;
            tick();
            chk("stream_valid", int'(o_valid), 1);
            chk("stream_byte", int'(o_byte), sexp[i]);
        end
        tick();

        // Overflow: hold + 4 in FIFO, sixth sample dropped
        i_ready = 0;
        for (int v = 10; v <= 15; v++) begin
            i_y_n = YW'(v); i_valid = 1;
            tick();
        end
        i_valid = 0;
        chk("ovf_level", int'(o_level), 4);
        chk("ovf_flag", int'(o_overflow), 1);
        chk("ovf_hold_byte", int'(o_byte), 0);
        i_ready = 1;
        collect(20, got);
        chk("ovf_count", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++)
            chk("ovf_order", got[i], (i % 2 == 0) ? 0 : 10 + i / 2);
        chk("ovf_sticky", int'(o_overflow), 1);
        i_clr_ovf = 1;
        tick();
        i_clr_ovf = 0;
        chk("ovf_clr", int'(o_overflow), 0);

        // Full FIFO with write on the LO-accept edge
        i_ready = 0;
        for (int v = 20; v <= 24; v++) begin
            i_y_n = YW'(v); i_valid = 1;
            tick();
        end
        i_valid = 0;
        chk("full_level", int'(o_level), 4);
        i_ready = 1;
        tick();
        chk("full_lo_byte", int'(o_byte), 8'h14);
        i_y_n = 25; i_valid = 1;
        tick();
        i_valid = 0;
        chk("full_sim_level", int'(o_level), 4);
        chk("full_sim_ovf", int'(o_overflow), 0);
        chk("full_sim_hi", int'(o_byte), 0);
        collect(20, got);
        chk("full_drain_count", got.size(), 10);

        // Reset mid-transfer in LO with three queued
        i_ready = 0;
        for (int v = 30; v <= 33; v++) begin
            i_y_n = YW'(v); i_valid = 1;
            tick();
        end
        i_valid = 0; i_ready = 1;
        tick();
        chk("mid_lo_byte", int'(o_byte), 8'h1E);
        chk("mid_level", int'(o_level), 3);
        #1 reset = 0;
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_byte", int'(o_byte), 0);
        chk("mid_rst_level", int'(o_level), 0);
        tick(); tick();
        reset = 1;
        tick();
        i_y_n = 40; i_valid = 1;
        tick();
        i_valid = 0;
        collect(10, got);
        chk("post_rst_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("post_rst_hi", got[0], 0);
            chk("post_rst_lo", got[1], 8'h28);
        end

        // Randomized traffic with backpressure
        for (int c = 0; c < 3000; c++) begin
            i_ready = 1'($urandom);
            i_valid = ($urandom_range(0, 9) < 4);
            i_y_n = YW'($urandom);
            i_clr_ovf = ($urandom_range(0, 19) == 0);
            tick();
        end
        i_valid = 0; i_clr_ovf = 0; i_ready = 1;
        for (int c = 0; c < 20; c++) tick();
        chk("final_idle", int'(o_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
